// File: rtl/pulp_cluster_package.sv
// Shared cluster constants: peripheral crossbar slot of the error slave and its response payload.
package pulp_cluster_package;

  localparam int unsigned SPER_ERROR_ID = 10;

  // Payload returned on every rejected access; resized by the user to its data width.
  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  typedef enum logic {
    RESP_OK  = 1'b0,
    RESP_ERR = 1'b1
  } resp_opc_e;

endpackage

// File: rtl/periph_err_resp_pipe.sv
// Fixed-depth {valid, id} delay line with synchronous active-high flush.
module periph_err_resp_pipe #(
  parameter int unsigned ID_WIDTH = 9,
  parameter int unsigned DEPTH    = 1
) (
  input  logic                clk_i,
  input  logic                flush_i,
  input  logic                valid_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                valid_o,
  output logic [ID_WIDTH-1:0] id_o
);

  logic [DEPTH-1:0]               r_valid;
  logic [DEPTH-1:0][ID_WIDTH-1:0] r_id;
  logic [ID_WIDTH-1:0]            w_id_in;

  // Idle slots carry a zero id so the output needs no extra masking downstream.
  assign w_id_in = valid_i ? id_i : '0;

  // Whole-vector shifts keep DEPTH=1 legal without special-casing the stage chain.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      r_valid <= '0;
      r_id    <= '0;
    end else begin
      r_valid <= (r_valid << 1) | DEPTH'(valid_i);
      r_id    <= (r_id << ID_WIDTH) | (DEPTH*ID_WIDTH)'(w_id_in);
    end
  end

  assign valid_o = r_valid[DEPTH-1];
  assign id_o    = r_id[DEPTH-1];

endmodule

// File: rtl/periph_error_slave.sv
// Terminating slave for the peripheral crossbar error port: grants everything,
// answers with a delayed error response and logs the first offending access.
module periph_error_slave
  import pulp_cluster_package::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned ID_WIDTH   = 9,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic                  r_opc_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  input  logic                  clr_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [ID_WIDTH-1:0]   err_id_o,
  output logic                  err_wen_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic                  err_irq_o
);

  localparam logic [DATA_WIDTH-1:0] LP_ERR_RDATA = DATA_WIDTH'(ERR_RDATA);

  logic                  w_accept;
  logic                  w_pipe_valid;
  logic [ID_WIDTH-1:0]   w_pipe_id;
  logic                  w_base_valid;
  logic [CNT_WIDTH-1:0]  w_base_cnt;
  logic                  w_capture;
  logic                  w_unused;

  logic                  r_err_valid;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [ID_WIDTH-1:0]   r_err_id;
  logic                  r_err_wen;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic                  r_err_irq;

  assign w_unused = ^{wdata_i, be_i};

  assign gnt_o    = req_i & ~rst_i;
  assign w_accept = req_i & gnt_o;

  periph_err_resp_pipe #(
    .ID_WIDTH (ID_WIDTH),
    .DEPTH    (LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .flush_i (rst_i),
    .valid_i (w_accept),
    .id_i    (id_i),
    .valid_o (w_pipe_valid),
    .id_o    (w_pipe_id)
  );

  assign r_valid_o = w_pipe_valid;
  assign r_opc_o   = w_pipe_valid ? RESP_ERR : RESP_OK;
  assign r_id_o    = w_pipe_valid ? w_pipe_id : '0;
  assign r_rdata_o = w_pipe_valid ? LP_ERR_RDATA : '0;

  // Clear is folded in ahead of the accept so a same-cycle access starts a fresh log.
  always_comb begin
    w_base_valid = r_err_valid & ~clr_i;
    w_base_cnt   = clr_i ? '0 : r_err_count;
    w_capture    = w_accept & ~w_base_valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_id    <= '0;
      r_err_wen   <= 1'b0;
      r_err_count <= '0;
      r_err_irq   <= 1'b0;
    end else begin
      r_err_irq <= w_capture;
      if (w_accept && !(&w_base_cnt)) begin
        r_err_count <= w_base_cnt + 1'b1;
      end else begin
        r_err_count <= w_base_cnt;
      end
      if (w_capture) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= add_i;
        r_err_id    <= id_i;
        r_err_wen   <= wen_i;
      end else if (clr_i) begin
        r_err_valid <= 1'b0;
        r_err_addr  <= '0;
        r_err_id    <= '0;
        r_err_wen   <= 1'b0;
      end
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
  assign err_id_o    = r_err_id;
  assign err_wen_o   = r_err_wen;
  assign err_count_o = r_err_count;
  assign err_irq_o   = r_err_irq;

endmodule

// File: tb/tb_periph_error_slave.sv
// Bench for periph_error_slave: two instances (LATENCY=1/CNT16/32-bit data and
// LATENCY=3/CNT4/16-bit data) share stimulus and are compared against a cycle history model.
module tb_periph_error_slave;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned HIST  = 4096;

  logic        clk = 1'b0;
  logic        rst, req, wen, clr;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic [8:0]  id;

  logic        a_gnt, a_rv, a_opc, a_ev, a_ewen, a_irq;
  logic [8:0]  a_rid, a_eid;
  logic [31:0] a_rdata, a_eaddr;
  logic [15:0] a_cnt;
  logic        b_gnt, b_rv, b_opc, b_ev, b_ewen, b_irq;
  logic [8:0]  b_rid, b_eid;
  logic [15:0] b_rdata;
  logic [31:0] b_eaddr;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  periph_error_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(9),
    .LATENCY(LAT_A), .CNT_WIDTH(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(a_gnt), .r_valid_o(a_rv),
    .r_opc_o(a_opc), .r_id_o(a_rid), .r_rdata_o(a_rdata), .clr_i(clr),
    .err_valid_o(a_ev), .err_addr_o(a_eaddr), .err_id_o(a_eid),
    .err_wen_o(a_ewen), .err_count_o(a_cnt), .err_irq_o(a_irq)
  );

  periph_error_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(16), .BE_WIDTH(2), .ID_WIDTH(9),
    .LATENCY(LAT_B), .CNT_WIDTH(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata[15:0]), .be_i(be[1:0]), .id_i(id), .gnt_o(b_gnt), .r_valid_o(b_rv),
    .r_opc_o(b_opc), .r_id_o(b_rid), .r_rdata_o(b_rdata), .clr_i(clr),
    .err_valid_o(b_ev), .err_addr_o(b_eaddr), .err_id_o(b_eid),
    .err_wen_o(b_ewen), .err_count_o(b_cnt), .err_irq_o(b_irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         h_acc [HIST];
  bit         h_rst [HIST];
  logic [8:0] h_id  [HIST];

  // Log model per instance (index 0 = A, 1 = B)
  bit          m_valid [2];
  bit          m_irq   [2];
  bit          m_wen   [2];
  logic [31:0] m_addr  [2];
  logic [8:0]  m_id    [2];
  int unsigned m_cnt   [2];
  int unsigned m_cw    [2] = '{16, 4};

  task automatic set_in(input bit r, input bit q, input logic [31:0] a, input bit w,
                        input logic [8:0] i, input bit c);
    rst = r; req = q; add = a; wen = w; id = i; clr = c;
    wdata = $urandom; be = 4'($urandom);
    h_acc[cyc] = q && !r;
    h_rst[cyc] = r;
    h_id[cyc]  = i;
    #1;
  endtask

  task automatic adv();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_valid[d] = 0; m_irq[d] = 0; m_wen[d] = 0; m_addr[d] = '0; m_id[d] = '0; m_cnt[d] = 0;
      end else begin
        m_irq[d] = 0;
        if (clr) begin
          m_valid[d] = 0; m_wen[d] = 0; m_addr[d] = '0; m_id[d] = '0; m_cnt[d] = 0;
        end
        if (req) begin
          if (!m_valid[d]) begin
            m_valid[d] = 1; m_irq[d] = 1; m_addr[d] = add; m_id[d] = id; m_wen[d] = wen;
          end
          if (m_cnt[d] < (32'd1 << m_cw[d]) - 1) m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // A response is visible L cycles after its accept unless a reset landed in between.
  function automatic bit exp_rv(input int lat);
    int a = cyc - lat;
    if (a < 0) return 0;
    if (!h_acc[a]) return 0;
    for (int j = a + 1; j < cyc; j++) if (h_rst[j]) return 0;
    return 1;
  endfunction

  function automatic logic [8:0] exp_rid(input int lat);
    return exp_rv(lat) ? h_id[cyc - lat] : 9'h0;
  endfunction

  task automatic test_reset();
    set_in(1, 1, 32'h0, 1, 9'h001, 0);
    checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got a=%b b=%b, want 0", a_gnt, b_gnt);
    end
    adv();
    set_in(0, 0, 32'h0, 1, 9'h0, 0);
    checks++;
    if ({a_rv, a_opc, a_rid, a_rdata, a_ev, a_eaddr, a_eid, a_ewen, a_cnt, a_irq} !== '0) begin
      errors++; $display("FAIL reset_outputs_a: got rv=%b cnt=%h ev=%b irq=%b, want all 0",
                         a_rv, a_cnt, a_ev, a_irq);
    end
    checks++;
    if ({b_rv, b_opc, b_rid, b_rdata, b_ev, b_eaddr, b_eid, b_ewen, b_cnt, b_irq} !== '0) begin
      errors++; $display("FAIL reset_outputs_b: got rv=%b cnt=%h ev=%b irq=%b, want all 0",
                         b_rv, b_cnt, b_ev, b_irq);
    end
    adv();
  endtask

  task automatic test_single_read();
    set_in(0, 1, 32'h1020_3C00, 1, 9'h004, 0);
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", a_gnt); end
    adv();
    set_in(0, 0, 32'h0, 1, 9'h0, 0);
    checks++;
    if ({a_rv, a_opc, a_rid} !== {1'b1, 1'b1, 9'h004}) begin
      errors++; $display("FAIL single_resp: got rv=%b opc=%b id=%h want 1 1 004", a_rv, a_opc, a_rid);
    end
    checks++;
    if (a_rdata !== 32'hBADACCE5) begin
      errors++; $display("FAIL single_rdata: got %h want badacce5", a_rdata);
    end
    checks++;
    if ({a_eaddr, a_irq, a_cnt, a_ev, a_ewen} !== {32'h1020_3C00, 1'b1, 16'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL single_log: got addr=%h irq=%b cnt=%0d want 10203c00 1 1",
                         a_eaddr, a_irq, a_cnt);
    end
    adv();
    set_in(0, 0, 32'h0, 1, 9'h0, 0);
    checks++;
    if (a_irq !== 1'b0 || a_rv !== 1'b0) begin
      errors++; $display("FAIL single_irq_pulse: got irq=%b rv=%b want 0 0", a_irq, a_rv);
    end
    adv();
  endtask

  task automatic test_back_to_back();
    logic [8:0]  ids [4] = '{9'h001, 9'h002, 9'h004, 9'h008};
    logic [31:0] adr [4];
    int t, irqs;
    set_in(0, 0, 32'h0, 1, 9'h0, 1);
    adv();
    t = cyc; irqs = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        adr[k] = $urandom;
        set_in(0, 1, adr[k], 0, ids[k], 0);
      end else begin
        set_in(0, 0, 32'h0, 1, 9'h0, 0);
      end
      irqs += int'(b_irq);
      checks++;
      if (b_rv !== (k >= 3 && k <= 6) ||
          b_rid !== ((k >= 3 && k <= 6) ? ids[k-3] : 9'h0) ||
          b_rdata !== ((k >= 3 && k <= 6) ? 16'hCCE5 : 16'h0)) begin
        errors++; $display("FAIL b2b_resp t+%0d: got rv=%b id=%h data=%h", k, b_rv, b_rid, b_rdata);
      end
      adv();
    end
    checks++;
    if ({b_cnt, b_eaddr, b_eid, b_ewen} !== {4'd4, adr[0], 9'h001, 1'b0}) begin
      errors++; $display("FAIL b2b_log: got cnt=%0d addr=%h id=%h wen=%b want 4 %h 001 0",
                         b_cnt, b_eaddr, b_eid, b_ewen, adr[0]);
    end
    checks++;
    if (irqs !== 1) begin errors++; $display("FAIL b2b_irq_count: got %0d want 1", irqs); end
    if (t < 0) errors++;
  endtask

  task automatic test_clear_accept();
    set_in(0, 0, 32'h0, 1, 9'h0, 1);
    adv();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1, $urandom, 1, 9'h002, 0);
      adv();
    end
    set_in(0, 1, 32'h1030_0000, 1, 9'h010, 1);
    checks++;
    if (a_cnt !== 16'd5) begin errors++; $display("FAIL clracc_pre_count: got %0d want 5", a_cnt); end
    adv();
    set_in(0, 0, 32'h0, 1, 9'h0, 0);
    checks++;
    if ({a_cnt, a_eaddr, a_eid, a_ev, a_irq} !== {16'd1, 32'h1030_0000, 9'h010, 1'b1, 1'b1}) begin
      errors++; $display("FAIL clracc_log: got cnt=%0d addr=%h id=%h ev=%b irq=%b want 1 10300000 010 1 1",
                         a_cnt, a_eaddr, a_eid, a_ev, a_irq);
    end
    checks++;
    if ({b_cnt, b_eaddr, b_irq} !== {4'd1, 32'h1030_0000, 1'b1}) begin
      errors++; $display("FAIL clracc_log_b: got cnt=%0d addr=%h irq=%b want 1 10300000 1",
                         b_cnt, b_eaddr, b_irq);
    end
    adv();
  endtask

  task automatic test_saturation();
    set_in(0, 0, 32'h0, 1, 9'h0, 1);
    adv();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, $urandom, 1'($urandom), 9'h080, 0);
      checks++;
      if (b_cnt !== 4'((i > 15) ? 15 : i)) begin
        errors++; $display("FAIL sat_count i=%0d: got %0d want %0d", i, b_cnt, (i > 15) ? 15 : i);
      end
      adv();
    end
    set_in(0, 0, 32'h0, 1, 9'h0, 0);
    checks++;
    if (b_cnt !== 4'd15 || a_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_final: got b=%0d a=%0d want 15 20", b_cnt, a_cnt);
    end
    adv();
  endtask

  task automatic test_reset_midflight();
    set_in(0, 1, 32'h2000_0000, 1, 9'h001, 0);
    adv();
    set_in(0, 1, 32'h2000_0004, 0, 9'h100, 0);
    adv();
    set_in(1, 0, 32'h0, 1, 9'h0, 0);
    adv();
    for (int k = 0; k < 6; k++) begin
      set_in(0, 0, 32'h0, 1, 9'h0, 0);
      if (k == 0) begin
        checks++;
        if ({b_rv, b_opc, b_rid, b_rdata, b_ev, b_eaddr, b_eid, b_ewen, b_cnt, b_irq,
             a_rv, a_opc, a_rid, a_rdata, a_ev, a_eaddr, a_eid, a_ewen, a_cnt, a_irq} !== '0) begin
          errors++; $display("FAIL midrst_outputs: got b_rv=%b b_cnt=%0d a_rv=%b a_cnt=%0d want all 0",
                             b_rv, b_cnt, a_rv, a_cnt);
        end
      end
      checks++;
      if (b_rv !== 1'b0) begin errors++; $display("FAIL midrst_rvalid k=%0d: got %b want 0", k, b_rv); end
      adv();
    end
  endtask

  task automatic test_random();
    logic [71:0] act_a, exp_a;
    logic [55:0] act_b, exp_b;
    bit rva, rvb;
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 39) == 0, 1'($urandom), $urandom, 1'($urandom),
             9'(1 << $urandom_range(0, 8)), $urandom_range(0, 9) == 0);
      rva = exp_rv(LAT_A);
      rvb = exp_rv(LAT_B);
      act_a = {a_gnt, a_rv, a_opc, a_rid, a_rdata[15:0], a_ev, a_eaddr[7:0], a_eid, a_ewen, a_cnt, a_irq};
      exp_a = {req & ~rst, rva, rva, exp_rid(LAT_A), rva ? 16'hCCE5 : 16'h0, m_valid[0],
               m_addr[0][7:0], m_id[0], m_wen[0], 16'(m_cnt[0]), m_irq[0]};
      checks++;
      if (act_a !== exp_a || a_rdata !== (rva ? 32'hBADACCE5 : 32'h0) || a_eaddr !== m_addr[0]) begin
        errors++; $display("FAIL rand_a cyc=%0d: got %h addr=%h want %h addr=%h",
                           cyc, act_a, a_eaddr, exp_a, m_addr[0]);
      end
      act_b = {b_gnt, b_rv, b_opc, b_rid, b_rdata, b_ev, b_eid, b_ewen, b_cnt, b_irq, 11'h0};
      exp_b = {req & ~rst, rvb, rvb, exp_rid(LAT_B), rvb ? 16'hCCE5 : 16'h0, m_valid[1],
               m_id[1], m_wen[1], 4'(m_cnt[1]), m_irq[1], 11'h0};
      checks++;
      if (act_b !== exp_b || b_eaddr !== m_addr[1]) begin
        errors++; $display("FAIL rand_b cyc=%0d: got %h addr=%h want %h addr=%h",
                           cyc, act_b, b_eaddr, exp_b, m_addr[1]);
      end
      adv();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_irq[d] = 0; m_wen[d] = 0; m_addr[d] = '0; m_id[d] = '0; m_cnt[d] = 0;
    end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_clear_accept();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
